// File: rtl/mem_responder.sv
// Fixed-latency responder for the core cache request interface. It is backed by
// a word-addressed 64-bit RAM and accepts one request at a time.
module mem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [63:0] addr_i,
  input  logic        data_wen_i,
  input  logic [63:0] data_i,
  output logic        data_valid_o,
  output logic [63:0] data_o
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_wen;
  logic [63:0] r_data;
  logic [63:0] r_mem [DEPTH];

  logic                  w_accept;
  logic [63:0]           w_req_addr;
  logic [63:0]           w_req_wdata;
  logic                  w_req_wen;
  logic [63:0]           w_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_enter_resp;
  logic                  w_unused_off;

  assign w_accept = (r_state == S_IDLE) && req_valid_i;

  // With LATENCY=1 the RESP entry edge is the acceptance edge, so the live request is used there
  assign w_req_addr  = (r_state == S_IDLE) ? addr_i     : r_addr;
  assign w_req_wdata = (r_state == S_IDLE) ? data_i     : r_wdata;
  assign w_req_wen   = (r_state == S_IDLE) ? data_wen_i : r_wen;

  assign w_off        = w_req_addr - BASE_ADDR;
  assign w_in_range   = (w_off[63:DEPTH_LOG2+3] == '0);
  assign w_idx        = w_off[DEPTH_LOG2+2:3];
  assign w_unused_off = ^w_off[2:0];

  // Gated by rst so a request seen while reset is held can never reach the RAM
  assign w_enter_resp = rst && (w_state_nxt == S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_valid_o = (r_state == S_RESP);
    data_o       = r_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_wen   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr_i;
      r_wdata <= data_i;
      r_wen   <= data_wen_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 64'd0;
    end else if (w_enter_resp) begin
      if (w_req_wen) begin
        r_data <= w_req_wdata;
      end else if (w_in_range) begin
        r_data <= r_mem[w_idx];
      end else begin
        r_data <= 64'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_resp && w_req_wen && w_in_range) begin
      r_mem[w_idx] <= w_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    a_latency_legal: assert (LATENCY >= 1 && LATENCY <= 15)
      else $fatal(1, "mem_responder: LATENCY %0d outside 1..15", LATENCY);
  end

endmodule
